console_uart_responder: RTL and testbench

//   Synthesizable responder on the core's data memory interface, replacing the simulation-only

---
 rtl/console_uart_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_console_uart_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/console_uart_responder.sv
// console_uart_responder
// Memory-mapped console for the core's data memory port. Byte writes to
// TXDATA are queued in a small FIFO and shifted out 8N1 on uart_tx; a
// STATUS word reports FIFO state, transmitter activity and a sticky overflow.
// Port names follow the core's data memory interface.

module console_uart_responder #(
   parameter logic [31:0] BASE_ADDRESS    = 32'h1000_0000,
   parameter int          CLKS_PER_BIT    = 16,
   parameter int          FIFO_ADDR_WIDTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_memory_interface_enable,
   input  logic        data_memory_interface_state,
   input  logic [31:0] data_memory_interface_address,
   input  logic [3:0]  data_memory_interface_frame_mask,
   inout  wire  [31:0] data_memory_interface_data,
   output logic        uart_tx,
   output logic        tx_busy
);

   // Access direction encoding used by the core (`READ / `WRITE).
   localparam logic STATE_READ  = 1'b0;
   localparam logic STATE_WRITE = 1'b1;

   localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]         CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [FIFO_ADDR_WIDTH:0] COUNT_FULL = (FIFO_ADDR_WIDTH + 1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } tx_state_t;

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   logic hit_tx;
   logic hit_st_rd;
   logic hit_st_wr;

   assign hit_tx    = data_memory_interface_enable
                    & (data_memory_interface_state == STATE_WRITE)
                    & (data_memory_interface_address == BASE_ADDRESS)
                    & data_memory_interface_frame_mask[3];
   assign hit_st_rd = data_memory_interface_enable
                    & (data_memory_interface_state == STATE_READ)
                    & (data_memory_interface_address == BASE_ADDRESS + 32'd4);
   assign hit_st_wr = data_memory_interface_enable
                    & (data_memory_interface_state == STATE_WRITE)
                    & (data_memory_interface_address == BASE_ADDRESS + 32'd4);

   // Only the low byte of the bus and the top enable bit carry meaning here.
   logic unused;
   assign unused = ^{data_memory_interface_data[31:8], data_memory_interface_frame_mask[2:0]};

   // ------------------------------------------------------------------
   // FIFO
   // ------------------------------------------------------------------
   logic [7:0]                 mem_q [DEPTH];
   logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_ADDR_WIDTH:0]   count_q, count_d;
   logic                       overflow_q, overflow_d;
   logic                       full;
   logic                       empty;
   logic                       push;
   logic                       pop;
   logic [7:0]                 rd_byte;

   assign full    = (count_q == COUNT_FULL);
   assign empty   = (count_q == '0);
   // Full is judged before the edge, so a simultaneous pop never rescues the byte.
   assign push    = hit_tx & ~full;
   assign rd_byte = mem_q[rd_ptr_q];

   // FIFO bookkeeping next-state: pointers wrap naturally at the pointer width.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (hit_tx && full)  overflow_d = 1'b1;
      else if (hit_st_wr)  overflow_d = 1'b0;
   end

   // FIFO pointer, count and sticky overflow registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // FIFO storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= data_memory_interface_data[7:0];
   end

   // ------------------------------------------------------------------
   // Transmitter FSM
   // ------------------------------------------------------------------
   tx_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             bit_end;

   assign bit_end = (cnt_q == CNT_LAST);

   // Next-state logic; the line level is computed from the next state so it
   // registers together with the state and a new frame starts one edge after the pop.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      pop     = 1'b0;
      tx_d    = 1'b1;
      busy_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = rd_byte;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = ST_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               cnt_d   = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (idx_q == 3'd7) state_d = ST_STOP;
               else               idx_d   = idx_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               // Chain straight into the next frame when more bytes wait.
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = rd_byte;
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (state_d == ST_START)     tx_d = 1'b0;
      else if (state_d == ST_DATA) tx_d = shift_d[0];
      busy_d = (state_d != ST_IDLE);
   end

   // Transmitter state register; reset abandons any partial frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

   assign uart_tx = tx_q;
   assign tx_busy = busy_q;

   // ------------------------------------------------------------------
   // STATUS read-back
   // ------------------------------------------------------------------
   logic [31:0] status;

   // Assemble the STATUS word; unused bits stay zero.
   always_comb begin
      status                         = '0;
      status[0]                      = full;
      status[1]                      = empty;
      status[2]                      = busy_q;
      status[3]                      = overflow_q;
      status[8 +: FIFO_ADDR_WIDTH+1] = count_q;
   end

   assign data_memory_interface_data = hit_st_rd ? status : {32{1'bz}};

endmodule

// File: tb/tb_console_uart_responder.sv
// tb_console_uart_responder
// Directed bench for the console UART responder with CLKS_PER_BIT=4 and a
// 16-byte FIFO. The shared data bus is pulled high so an undriven bus reads
// back as all ones.

module tb_console_uart_responder;

   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam int          CPB  = 4;
   localparam logic        RD   = 1'b0;
   localparam logic        WR   = 1'b1;
   localparam logic [31:0] UNDRIVEN = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic        st;
   logic [31:0] addr;
   logic [3:0]  mask;
   logic        drv_en;
   logic [31:0] drv_data;
   tri1  [31:0] bus;
   logic        uart_tx;
   logic        tx_busy;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   assign bus = drv_en ? drv_data : {32{1'bz}};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   console_uart_responder #(
      .BASE_ADDRESS    (BASE),
      .CLKS_PER_BIT    (CPB),
      .FIFO_ADDR_WIDTH (4)
   ) dut (
      .clk                              (clk),
      .reset                            (reset),
      .data_memory_interface_enable     (en),
      .data_memory_interface_state      (st),
      .data_memory_interface_address    (addr),
      .data_memory_interface_frame_mask (mask),
      .data_memory_interface_data       (bus),
      .uart_tx                          (uart_tx),
      .tx_busy                          (tx_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      en       = 1'b0;
      st       = RD;
      addr     = '0;
      mask     = '0;
      drv_en   = 1'b0;
      drv_data = '0;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      en       = 1'b1;
      st       = WR;
      addr     = a;
      mask     = m;
      drv_en   = 1'b1;
      drv_data = d;
      step();
      idle_bus();
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
      en     = 1'b1;
      st     = RD;
      addr   = a;
      mask   = 4'b1111;
      drv_en = 1'b0;
      #2;
      v = bus;
      step();
      idle_bus();
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) step();
   endtask

   initial begin
      logic [31:0] rd;
      logic [9:0]  fb;
      int          t0;
      int          target;

      idle_bus();
      reset = 1'b1;
      repeat (3) step();
      check("reset_tx", {31'b0, uart_tx}, 32'd1);
      check("reset_busy", {31'b0, tx_busy}, 32'd0);
      reset = 1'b0;
      step();
      check("post_reset_tx", {31'b0, uart_tx}, 32'd1);
      check("post_reset_busy", {31'b0, tx_busy}, 32'd0);
      bus_read(BASE + 32'd4, rd);
      check("post_reset_status", rd, 32'h0000_0002);

      // Single byte 0x41: start, 1,0,0,0,0,0,1,0, stop, 4 cycles per bit.
      bus_write(BASE, 32'h0000_0041, 4'b1000);
      check("single_pre_tx", {31'b0, uart_tx}, 32'd1);
      fb = {1'b1, 8'h41, 1'b0};
      for (int k = 0; k < 10 * CPB; k++) begin
         step();
         check($sformatf("single_tx_c%0d", k), {31'b0, uart_tx}, {31'b0, fb[k / CPB]});
         check($sformatf("single_busy_c%0d", k), {31'b0, tx_busy}, 32'd1);
      end
      step();
      check("single_end_tx", {31'b0, uart_tx}, 32'd1);
      check("single_end_busy", {31'b0, tx_busy}, 32'd0);

      // 18 back-to-back bytes: first popped, 16 stored, last dropped.
      t0 = 0;
      for (int i = 0; i < 18; i++) begin
         en       = 1'b1;
         st       = WR;
         addr     = BASE;
         mask     = 4'b1000;
         drv_en   = 1'b1;
         drv_data = {24'h0, 8'h30 + 8'(i)};
         step();
         if (i == 0) t0 = cyc;
      end
      idle_bus();
      // Byte 1 is on the wire at this point, so the busy bit joins full and overflow.
      bus_read(BASE + 32'd4, rd);
      check("burst_status", rd, 32'h0000_100D);
      bus_write(BASE + 32'd4, 32'hFFFF_FFFF, 4'b0000);
      bus_read(BASE + 32'd4, rd);
      check("burst_status_cleared", rd, 32'h0000_1005);
      // Frame f occupies edges t0+1+40f .. t0+40+40f; sample the middle of each bit.
      for (int f = 0; f < 17; f++) begin
         fb = {1'b1, 8'h30 + 8'(f), 1'b0};
         for (int b = 0; b < 10; b++) begin
            target = t0 + 3 + 10 * CPB * f + CPB * b;
            if (target >= cyc) begin
               wait_until(target);
               check($sformatf("burst_f%0d_b%0d", f, b), {31'b0, uart_tx}, {31'b0, fb[b]});
            end
         end
      end
      wait_until(t0 + 1 + 17 * 10 * CPB);
      check("burst_end_tx", {31'b0, uart_tx}, 32'd1);
      check("burst_end_busy", {31'b0, tx_busy}, 32'd0);
      bus_read(BASE + 32'd4, rd);
      check("burst_end_status", rd, 32'h0000_0002);

      // Ignored accesses: wrong byte lane, wrong address, read of TXDATA.
      bus_write(BASE, 32'h0000_0055, 4'b0100);
      bus_write(BASE + 32'd8, 32'h0000_0066, 4'b1000);
      bus_read(BASE, rd);
      check("read_txdata_undriven", rd, UNDRIVEN);
      bus_read(BASE + 32'd8, rd);
      check("read_base8_undriven", rd, UNDRIVEN);
      #2;
      check("idle_bus_undriven", bus, UNDRIVEN);
      repeat (3) step();
      check("ignored_busy", {31'b0, tx_busy}, 32'd0);
      check("ignored_tx", {31'b0, uart_tx}, 32'd1);
      bus_read(BASE + 32'd4, rd);
      check("ignored_status", rd, 32'h0000_0002);

      // Reset in the middle of a data bit with three bytes still queued.
      t0 = 0;
      for (int i = 0; i < 4; i++) begin
         en       = 1'b1;
         st       = WR;
         addr     = BASE;
         mask     = 4'b1000;
         drv_en   = 1'b1;
         drv_data = 32'h0000_0000;
         step();
         if (i == 0) t0 = cyc;
      end
      idle_bus();
      wait_until(t0 + 1 + 2 * CPB + 1);
      check("mid_data_tx_low", {31'b0, uart_tx}, 32'd0);
      reset = 1'b1;
      step();
      check("midreset_tx", {31'b0, uart_tx}, 32'd1);
      check("midreset_busy", {31'b0, tx_busy}, 32'd0);
      bus_read(BASE + 32'd4, rd);
      check("midreset_status", rd, 32'h0000_0002);
      reset = 1'b0;
      for (int k = 0; k < 60; k++) begin
         step();
         check($sformatf("after_reset_tx_c%0d", k), {31'b0, uart_tx}, 32'd1);
      end
      check("after_reset_busy", {31'b0, tx_busy}, 32'd0);

      // STATUS read during the stop bit with one byte waiting.
      t0 = 0;
      for (int i = 0; i < 2; i++) begin
         en       = 1'b1;
         st       = WR;
         addr     = BASE;
         mask     = 4'b1000;
         drv_en   = 1'b1;
         drv_data = (i == 0) ? 32'h0000_00A5 : 32'h0000_005A;
         step();
         if (i == 0) t0 = cyc;
      end
      idle_bus();
      wait_until(t0 + 1 + 9 * CPB + 1);
      check("stop_bit_tx", {31'b0, uart_tx}, 32'd1);
      bus_read(BASE + 32'd4, rd);
      check("stop_bit_status", rd, 32'h0000_0104);
      wait_until(t0 + 1 + 10 * CPB + 2);
      check("second_frame_start", {31'b0, uart_tx}, 32'd0);
      wait_until(t0 + 1 + 20 * CPB);
      check("pair_end_busy", {31'b0, tx_busy}, 32'd0);
      bus_read(BASE + 32'd4, rd);
      check("pair_end_status", rd, 32'h0000_0002);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
